// File: rtl/fp_pkg.sv
// Shared float helpers: default field widths, bias, result flag positions and
// field-slice functions for the default single-precision-like format.
package fp_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;
  localparam int FW_DEF    = EXP_W_DEF + MAN_W_DEF;
  localparam int BIAS_DEF  = (1 << (EXP_W_DEF - 1)) - 1;

  // Result flag bit positions
  localparam int FLAG_NEG  = 0;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_W    = 2;

  // Exponent bias for an arbitrary exponent width
  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Exponent field of a default-format word
  function automatic logic [EXP_W_DEF-1:0] exp_field(input logic [FW_DEF-1:0] f);
    return f[FW_DEF-1 -: EXP_W_DEF];
  endfunction

  // Mantissa field of a default-format word
  function automatic logic [MAN_W_DEF-1:0] man_field(input logic [FW_DEF-1:0] f);
    return f[MAN_W_DEF-1:0];
  endfunction

  // Build a default-format word from its fields
  function automatic logic [FW_DEF-1:0] fp_pack(input logic [EXP_W_DEF-1:0] e,
                                                input logic [MAN_W_DEF-1:0] m);
    return {e, m};
  endfunction

endpackage

// File: rtl/fp_norm_round.sv
// Normalise and round an unsigned magnitude: leading-zero count, left shift,
// round-to-nearest-even on guard/rest/sticky, exponent adjust and underflow.
// Purely combinational so the caller decides where the register boundary sits.
module fp_norm_round #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int GRD_W = 3
) (
  input  logic [MAN_W+GRD_W:0]      mag,      // value with hidden-bit position at the MSB
  input  logic                      sticky,   // nonzero bits below mag LSB
  input  logic signed [EXP_W:0]     exp_top,  // biased exponent if mag MSB were set
  output logic [EXP_W+MAN_W-1:0]    f,
  output logic                      zero      // result is zero or underflowed
);

  localparam int AW  = MAN_W + 1 + GRD_W;
  localparam int XW  = EXP_W + 1;
  localparam int LZW = $clog2(AW + 1);

  logic [LZW-1:0]    lzc;
  logic [AW-1:0]     norm;
  logic [MAN_W-1:0]  man_t;
  logic [GRD_W:0]    low;
  logic              guard;
  logic              rest;
  logic              round_up;
  logic [MAN_W:0]    man_r;
  logic              carry;
  logic signed [XW-1:0] exp_adj;

  // Leading-zero count: the highest set bit wins because later iterations overwrite
  always_comb begin
    lzc = LZW'(AW);
    for (int i = 0; i < AW; i++) begin
      if (mag[i]) lzc = LZW'(AW - 1 - i);
    end
  end

  // Shift, round to nearest even, then fix up the exponent
  always_comb begin
    norm     = mag << lzc;
    man_t    = norm[AW-2:GRD_W];
    low      = {norm[GRD_W-1:0], sticky};
    guard    = low[GRD_W];
    rest     = |low[GRD_W-1:0];
    round_up = guard && (rest || norm[GRD_W]);
    man_r    = {1'b0, man_t} + {{MAN_W{1'b0}}, round_up};
    carry    = man_r[MAN_W];
    exp_adj  = exp_top - $signed({{(XW-LZW){1'b0}}, lzc})
                       + $signed({{(XW-1){1'b0}}, carry});
    zero     = !norm[AW-1] || exp_adj[XW-1] || (exp_adj == '0);
    f        = zero ? '0 : {exp_adj[EXP_W-1:0], man_r[MAN_W-1:0]};
  end

endmodule

// File: rtl/fp_const_sub_pipe.sv
// Three-stage pipelined unsigned-float subtractor computing C - x for a
// build-time constant C, with sideband carry-through and NEG/ZERO flags.
//
// Handshake: a word moves in on a cycle where in_valid && in_ready; a result
// moves out on a cycle where out_valid && out_ready. One global enable
// en = !v3 || out_ready advances every stage together; in_ready equals en, so
// when the last stage is full and downstream stalls, the whole pipe freezes
// (data, sideband and flags held) and outputs stay stable.
module fp_const_sub_pipe
  import fp_pkg::*;
#(
  parameter int               EXP_W = EXP_W_DEF,
  parameter int               MAN_W = MAN_W_DEF,
  parameter int               GRD_W = 3,
  parameter int               C_EXP = 127,
  parameter logic [MAN_W-1:0] C_MAN = MAN_W'('h400000),
  parameter int               SB_W  = 31
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W-1:0] in_x,
  input  logic [SB_W-1:0]        in_sb,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W-1:0] out_f,
  output logic [SB_W-1:0]        out_sb,
  output logic [FLAG_W-1:0]      out_flag
);

  localparam int FW = EXP_W + MAN_W;
  localparam int AW = MAN_W + 1 + GRD_W;

  localparam logic [EXP_W-1:0]        C_E     = EXP_W'(C_EXP);
  localparam logic [EXP_W:0]          C_E_W   = (EXP_W+1)'(C_EXP);
  localparam logic [EXP_W:0]          AW_D    = (EXP_W+1)'(AW);
  localparam logic signed [EXP_W:0]   C_E_TOP = (EXP_W+1)'(C_EXP);
  localparam logic [AW-1:0]           C_AL    = {1'b1, C_MAN, {GRD_W{1'b0}}};

  logic en;
  logic v1, v2, v3;

  // Stage 1 combinational align
  logic [EXP_W-1:0] x_exp;
  logic [MAN_W-1:0] x_man;
  logic [AW-1:0]    x_full;
  logic [EXP_W:0]   d;
  logic [AW-1:0]    a_al;
  logic             a_st;
  logic             a_neg;
  logic             a_zero;

  // Stage 1 registers
  logic [AW-1:0]    s1_al;
  logic             s1_st;
  logic             s1_neg;
  logic             s1_zero;
  logic [SB_W-1:0]  s1_sb;

  // Stage 2 combinational subtract and registers
  logic [AW-1:0]    b_diff;
  logic [AW-1:0]    s2_diff;
  logic             s2_st;
  logic             s2_neg;
  logic             s2_zero;
  logic [SB_W-1:0]  s2_sb;

  // Stage 3 normalise/round result
  logic [FW-1:0]    nr_f;
  logic             nr_zero;

  assign en        = !v3 || out_ready;
  assign in_ready  = en;
  assign out_valid = v3;

  assign x_exp  = in_x[FW-1 -: EXP_W];
  assign x_man  = in_x[MAN_W-1:0];
  assign x_full = {1'b1, x_man, {GRD_W{1'b0}}};

  // Align x to C's exponent and classify x against C
  always_comb begin
    a_al   = '0;
    a_st   = 1'b0;
    a_neg  = 1'b0;
    a_zero = 1'b0;
    d      = C_E_W - {1'b0, x_exp};
    if (x_exp == '0) begin
      // x is exactly zero: nothing to subtract
      a_al = '0;
    end else if (x_exp > C_E) begin
      a_neg = 1'b1;
    end else if (x_exp == C_E) begin
      if (x_man > C_MAN)       a_neg  = 1'b1;
      else if (x_man == C_MAN) a_zero = 1'b1;
      else                     a_al   = x_full;
    end else if (d >= AW_D) begin
      // x lies entirely below the guard bits and only marks inexactness
      a_st = 1'b1;
    end else begin
      a_al = x_full >> d;
      a_st = |(x_full & ~({AW{1'b1}} << d));
    end
  end

  // Subtract aligned x from C; the sticky borrow accounts for the dropped tail of x
  always_comb begin
    if (s1_neg || s1_zero) b_diff = '0;
    else                   b_diff = C_AL - s1_al - {{(AW-1){1'b0}}, s1_st};
  end

  fp_norm_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W),
    .GRD_W (GRD_W)
  ) u_norm_round (
    .mag     (s2_diff),
    .sticky  (s2_st),
    .exp_top (C_E_TOP),
    .f       (nr_f),
    .zero    (nr_zero)
  );

  // Stage data registers: advance on en, no reset needed
  always_ff @(posedge clk) begin
    if (en) begin
      s1_al   <= a_al;
      s1_st   <= a_st;
      s1_neg  <= a_neg;
      s1_zero <= a_zero;
      s1_sb   <= in_sb;
      s2_diff <= b_diff;
      s2_st   <= s1_st && !(s1_neg || s1_zero);
      s2_neg  <= s1_neg;
      s2_zero <= s1_zero;
      s2_sb   <= s1_sb;
    end
  end

  // Valid bits and output registers: cleared on reset, advance on en
  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      out_f    <= '0;
      out_sb   <= '0;
      out_flag <= '0;
    end else if (en) begin
      v1                  <= in_valid;
      v2                  <= v1;
      v3                  <= v2;
      out_f               <= (s2_neg || s2_zero || nr_zero) ? '0 : nr_f;
      out_sb              <= s2_sb;
      out_flag[FLAG_NEG]  <= s2_neg;
      out_flag[FLAG_ZERO] <= !s2_neg && (s2_zero || nr_zero);
    end
  end

endmodule
